// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter slice.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned PERF_CNT_W = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr_i.
module mult_rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               grant_valid_o
);

  int unsigned     idx;
  logic [ID_W-1:0] idx_w;
  logic            found;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    idx_w      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx   = (32'(rr_ptr_i) + off) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!found && req_valid_i[idx_w]) begin
        found          = 1'b1;
        grant_o[idx_w] = 1'b1;
        grant_id_o     = idx_w;
      end
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/multiplier.sv
// Unsigned DATA_W x DATA_W multiplier, zero-extended to PROD_W, with LAT output
// register stages (LAT=0 gives a purely combinational product).
module multiplier #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PROD_W = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  output logic [PROD_W-1:0] product
);

  logic [2*DATA_W-1:0] full;
  logic [PROD_W-1:0]   prod_ext;

  assign full     = num1 * num2;
  assign prod_ext = PROD_W'(full);

  if (LAT == 0) begin : g_comb
    assign product = prod_ext;
  end else begin : g_pipe
    logic [PROD_W-1:0] pipe_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned s = 0; s < LAT; s++) pipe_q[s] <= '0;
      end else begin
        pipe_q[0] <= prod_ext;
        for (int unsigned s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end

    assign product = pipe_q[LAT-1];
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier between NUM_REQ requesters.
// Optional per-requester accept counters when MULT_ARB_PERF_EN is defined.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PROD_W  = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_num1,
  input  logic [NUM_REQ*DATA_W-1:0] req_num2,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [clog2(NUM_REQ)-1:0] resp_id,
  output logic [PROD_W-1:0]         resp_product,
  output logic                      busy
`ifdef MULT_ARB_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_cnt
`endif
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(MUL_LAT + 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [PROD_W-1:0]   mul_product;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_valid;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid_i   (req_valid),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid)
  );

  // The operand registers act as the first multiplier stage, so the shared
  // multiplier carries MUL_LAT-1 internal stages and prod_q closes the latency.
  multiplier #(
    .DATA_W (DATA_W),
    .PROD_W (PROD_W),
    .LAT    (MUL_LAT - 1)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .num1    (op_a_q),
    .num2    (op_b_q),
    .product (mul_product)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    prod_d     = prod_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          req_ready = grant;
          op_a_d    = req_num1[32'(grant_id)*DATA_W +: DATA_W];
          op_b_d    = req_num2[32'(grant_id)*DATA_W +: DATA_W];
          id_d      = grant_id;
          rr_ptr_d  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          prod_d  = mul_product;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
    end
  end

  assign resp_id      = id_q;
  assign resp_product = prod_q;
  assign busy         = (state_q != ST_IDLE);

`ifdef MULT_ARB_PERF_EN
  logic                  accept;
  logic [PERF_CNT_W-1:0] perf_q [NUM_REQ];

  assign accept = (state_q == ST_IDLE) && grant_valid;

  // Clear has priority over a same-cycle accept; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) perf_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (perf_clr) perf_q[i] <= '0;
        else if (accept && grant[i] && (perf_q[i] != '1)) perf_q[i] <= perf_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) perf_cnt[i*PERF_CNT_W +: PERF_CNT_W] = perf_q[i];
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, scoreboard monitor, corner sequences.
module tb_mult_arbiter;

  localparam int TB_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_num1;
  logic [31:0] req_num2;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [31:0] resp_product;
  logic        busy;
`ifdef MULT_ARB_PERF_EN
  logic        perf_clr;
  logic [63:0] perf_cnt;
`endif

  mult_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .PROD_W  (32),
    .MUL_LAT (TB_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_num1     (req_num1),
    .req_num2     (req_num2),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
`ifdef MULT_ARB_PERF_EN
    ,
    .perf_clr     (perf_clr),
    .perf_cnt     (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  typedef struct {
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t        sb_q[$];
  int          model_ptr = 0;
  int          n_acc = 0, n_resp = 0, n_rise = 0;
  int          last_acc_id = 0;
  int unsigned last_acc_cyc = 0, last_resp_cyc = 0;
  logic [31:0] last_resp_prod = '0;
  int          acc_ids[$];
  int unsigned acc_cycs[$];
  logic        prev_rv = 1'b0;

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (v[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  // Monitor: push expectations on accept, pop and compare on response handshake.
  always @(negedge clk) begin : monitor
    logic [3:0] hs;
    exp_t       e;
    int         id;
    if (!rst_n) begin
      sb_q.delete();
      model_ptr = 0;
      prev_rv   = 1'b0;
    end else begin
      hs = req_valid & req_ready;
      if (busy) check("ready_while_busy", req_ready, 0);
      if (hs != 4'b0000) begin
        check("grant", req_ready, model_grant(req_valid, model_ptr));
        id = 0;
        for (int k = 3; k >= 0; k--) if (hs[k]) id = k;
        e.id   = id;
        e.prod = 32'(req_num1[id*8 +: 8]) * 32'(req_num2[id*8 +: 8]);
        sb_q.push_back(e);
        model_ptr    = (id + 1) % 4;
        last_acc_id  = id;
        last_acc_cyc = cyc;
        acc_ids.push_back(id);
        acc_cycs.push_back(cyc);
        n_acc++;
      end
      if (resp_valid && !prev_rv) begin
        n_rise++;
        check("latency", cyc - last_acc_cyc, TB_LAT + 1);
      end
      prev_rv = resp_valid;
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_resp: got id %0d product %0h expected no response", resp_id, resp_product);
        end else begin
          e = sb_q.pop_front();
          check("resp_id", resp_id, e.id);
          check("resp_product", resp_product, e.prod);
        end
        last_resp_cyc  = cyc;
        last_resp_prod = resp_product;
        n_resp++;
      end
    end
  end

  task automatic wait_acc(input int start, input int bound);
    for (int k = 0; k < bound && n_acc == start; k++) begin
      @(negedge clk); #2;
    end
    check("acc_timeout", n_acc != start, 1);
  endtask

  task automatic wait_resp(input int start, input int bound);
    for (int k = 0; k < bound && n_resp == start; k++) begin
      @(negedge clk); #2;
    end
    check("resp_timeout", n_resp != start, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) @(posedge clk);
    #1;
    check("idle_timeout", busy, 0);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] n1;
    logic [31:0] n2;
    int          id;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int s, r;
    vecs[0] = '{4'b0100, 32'h000C_0000, 32'h000A_0000, 2, 32'h0000_0078};
    vecs[1] = '{4'b1111, 32'hFF05_0607, 32'hFF05_0607, 3, 32'h0000_FE01};
    vecs[2] = '{4'b1111, 32'h0102_0300, 32'h0102_03FF, 0, 32'h0000_0000};
    vecs[3] = '{4'b0001, 32'h0000_0011, 32'h0000_0010, 0, 32'h0000_0110};
    vecs[4] = '{4'b1001, 32'h8000_0001, 32'h0200_0001, 3, 32'h0000_0100};
    vecs[5] = '{4'b0110, 32'h0000_0700, 32'h0000_0900, 1, 32'h0000_003F};

    rst_n = 1'b0; req_valid = '0; req_num1 = '0; req_num2 = '0; resp_ready = 1'b1;
`ifdef MULT_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_product", resp_product, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Reset in the middle of WAIT discards the op.
    @(posedge clk); #1;
    req_valid = 4'b1000; req_num1 = 32'h0500_0000; req_num2 = 32'h0700_0000;
    s = n_acc;
    wait_acc(s, 10);
    check("mid_id", last_acc_id, 3);
    @(posedge clk); #1;
    req_valid = '0;
    check("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_resp_valid", resp_valid, 0);
    check("mid_req_ready", req_ready, 0);
    check("mid_resp_id", resp_id, 0);
    check("mid_resp_product", resp_product, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r = n_rise;
    repeat (6) @(posedge clk);
    #1;
    check("no_resp_after_reset", n_rise, r);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid = vecs[i].v; req_num1 = vecs[i].n1; req_num2 = vecs[i].n2;
      r = n_resp;
      s = n_acc;
      wait_acc(s, 20);
      check("tbl_id", last_acc_id, vecs[i].id);
      @(posedge clk); #1;
      req_valid = '0;
      wait_resp(r, 20);
      check("tbl_product", last_resp_prod, vecs[i].prod);
    end

    // Fairness from a fresh pointer.
    wait_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acc_ids.delete(); acc_cycs.delete();
    @(posedge clk); #1;
    req_valid = 4'hF; req_num1 = 32'h0403_0201; req_num2 = 32'h1010_1010;
    s = n_acc;
    for (int k = 0; k < 80 && n_acc < s + 5; k++) begin
      @(negedge clk); #2;
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("fair_count", n_acc - s, 5);
    for (int i = 0; i < 5 && i < acc_ids.size(); i++) check("fair_order", acc_ids[i], i % 4);
    for (int i = 1; i < 5 && i < acc_cycs.size(); i++)
      check("fair_spacing", acc_cycs[i] - acc_cycs[i-1], TB_LAT + 2);
    wait_idle();

    // Backpressure: response held while other requests wait.
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 4'b0011; req_num1 = 32'h0000_0905; req_num2 = 32'h0000_0B03;
    s = n_acc;
    wait_acc(s, 20);
    check("bp_id", last_acc_id, 1);
    r = n_rise;
    for (int k = 0; k < 20 && n_rise == r; k++) begin
      @(negedge clk); #2;
    end
    check("bp_rise", n_rise != r, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("bp_valid", resp_valid, 1);
      check("bp_hold_id", resp_id, 1);
      check("bp_hold_product", resp_product, 32'h63);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    s = n_acc; r = n_resp;
    wait_resp(r, 5);
    wait_acc(s, 5);
    check("bp_next_accept", last_acc_cyc - last_resp_cyc, 1);
    check("bp_next_id", last_acc_id, 0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

`ifdef MULT_ARB_PERF_EN
    @(posedge clk); #1 perf_clr = 1'b1;
    @(posedge clk); #1 perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 4'b0010; req_num1 = 32'h0000_0300; req_num2 = 32'h0000_0400;
      r = n_resp; s = n_acc;
      wait_acc(s, 20);
      @(posedge clk); #1 req_valid = '0;
      wait_resp(r, 20);
    end
    #1;
    check("perf_slice1", perf_cnt[31:16], 3);
    wait_idle();
    @(posedge clk); #1;
    req_valid = 4'b0010; perf_clr = 1'b1;
    s = n_acc;
    wait_acc(s, 5);
    @(posedge clk); #1;
    perf_clr = 1'b0; req_valid = '0;
    check("perf_clr_wins", perf_cnt[31:16], 0);
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
